// File: rtl/host_bus_master.sv
// Asynchronous host-bus master: one request at a time, run as SETUP/STROBE/HOLD/RESP phases.
// Define HOST_MASTER_WAIT_EN to enable HOST_nWAIT strobe stretching with a stall timeout.
//
// state  | meaning
// IDLE   | ready for a request, bus released
// SETUP  | nCS low, address/data driven, strobes high
// STROBE | nOE (read) or nWE (write) low
// HOLD   | strobes high, nCS/address/data held
// RESP   | nCS high, rsp_valid pulse
module host_bus_master #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 3,
    parameter int HOLD_CYC    = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [20:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        HOST_nCS,
    output logic        HOST_nOE,
    output logic        HOST_nWE,
    output logic [20:0] HOST_ADD,
    output logic [15:0] HOST_DO,
    input  logic [15:0] HOST_DI,
    input  logic        HOST_nWAIT
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [20:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        ncs_q, ncs_d;
    logic        noe_q, noe_d;
    logic        nwe_q, nwe_d;

`ifdef HOST_MASTER_WAIT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] stall_q, stall_d;
    logic       err_q, err_d;
`else
    logic wait_unused;
    assign wait_unused = HOST_nWAIT ^ (^8'(TIMEOUT_CYC));
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
`ifdef HOST_MASTER_WAIT_EN
        stall_d = stall_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    data_d  = req_wdata;
`ifdef HOST_MASTER_WAIT_EN
                    stall_d = 8'd0;
                    err_d   = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
`ifdef HOST_MASTER_WAIT_EN
                // A stalled cycle freezes the strobe counter; too many stalls abort with an error.
                if (!HOST_nWAIT) begin
                    if (stall_q == TO_LAST) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                        err_d   = 1'b1;
                        rdata_d = 16'h0000;
                    end else begin
                        stall_d = stall_q + 8'd1;
                    end
                end else
`endif
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    rdata_d = wr_q ? 16'h0000 : HOST_DI;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered copies of what the next state demands.
        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
        ncs_d   = !((state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD));
        noe_d   = !((state_d == STROBE) && !wr_d);
        nwe_d   = !((state_d == STROBE) && wr_d);
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 21'd0;
            data_q  <= 16'h0000;
            rdata_q <= 16'h0000;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            ncs_q   <= 1'b1;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
`ifdef HOST_MASTER_WAIT_EN
            stall_q <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            ncs_q   <= ncs_d;
            noe_q   <= noe_d;
            nwe_q   <= nwe_d;
`ifdef HOST_MASTER_WAIT_EN
            stall_q <= stall_d;
            err_q   <= err_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign HOST_nCS  = ncs_q;
    assign HOST_nOE  = noe_q;
    assign HOST_nWE  = nwe_q;
    assign HOST_ADD  = addr_q;
    assign HOST_DO   = data_q;
`ifdef HOST_MASTER_WAIT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: doc/host_bus_master.md
HOST_BUS_MASTER -- requirements
Module: host_bus_master

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles the address and nCS are held before the strobe; legal range 1..15.
REQ-002 Parameter STROBE_CYC, default 3: nOE/nWE low cycles; legal range 2..15.
REQ-003 Parameter HOLD_CYC, default 1: cycles nCS and address are held after the strobe; legal range 1..15.
REQ-004 Parameter TIMEOUT_CYC, default 255: maximum wait-extension cycles (used only with HOST_MASTER_WAIT_EN); legal range 1..255.
REQ-005 The clock is clk, a 1-bit input and the rising-edge system clock.
REQ-006 The reset is nRESET, a 1-bit input, asynchronous and active-low.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  master can accept a request.
REQ-009 req_write  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  21  bus address.
REQ-011 req_wdata  in  16  write data.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  16  read data, valid with rsp_valid.
REQ-014 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-015 HOST_nCS / HOST_nOE / HOST_nWE  out  1 each  active-low bus strobes.
REQ-016 HOST_ADD  out  21  bus address.
REQ-017 HOST_DO  out  16  write data to the slave HDI.
REQ-018 HOST_DI  in  16  read data from the slave HDO.
REQ-019 HOST_nWAIT  in  1  slave wait, active-low.

Function
REQ-020 The state machine SHALL have the states IDLE, SETUP, STROBE, HOLD and RESP; every bus output SHALL be driven from a register.
REQ-021 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on the clk edge where req_valid and req_ready are both 1, latching req_write, req_addr and req_wdata, and the FSM SHALL move to SETUP.
REQ-022 req_* changes while not in IDLE SHALL have no effect on the bus.
REQ-023 In SETUP, HOST_nCS SHALL be 0, HOST_ADD and HOST_DO SHALL carry the latched values, and nOE/nWE SHALL be 1 for SETUP_CYC cycles, after which the FSM moves to STROBE.
REQ-024 In STROBE, HOST_nWE (write) or HOST_nOE (read) SHALL be 0 for STROBE_CYC cycles; HOST_nOE and HOST_nWE SHALL never be 0 simultaneously.
REQ-025 For a read, HOST_DI SHALL be captured into rsp_rdata on the clk edge that ends the final STROBE cycle; for a write, rsp_rdata SHALL be 16'h0000.
REQ-026 In HOLD, nOE/nWE SHALL be 1 while nCS, HOST_ADD and HOST_DO are unchanged, for HOLD_CYC cycles.
REQ-027 In RESP, HOST_nCS SHALL be 1 and rsp_valid SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE; there is no response back-pressure.
REQ-028 Latency from the acceptance edge to rsp_valid high SHALL be SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles; back-to-back transactions SHALL have HOST_nCS high for at least 2 cycles between them.
REQ-029 Phase counters SHALL be 4 bits and SHALL reload on every state entry; a parameter value of 1 SHALL mean exactly one cycle.

Reset
REQ-030 While nRESET is 0, the FSM SHALL be IDLE, req_ready SHALL be 1, rsp_valid and rsp_err SHALL be 0, rsp_rdata SHALL be 0, HOST_nCS, HOST_nOE and HOST_nWE SHALL be 1, and HOST_ADD and HOST_DO SHALL be 0.
REQ-031 Assertion of nRESET mid-transaction SHALL deassert all strobes immediately (asynchronously), SHALL produce no rsp_valid, and SHALL discard the transaction.

Configuration
REQ-032 With HOST_MASTER_WAIT_EN defined, each STROBE cycle in which HOST_nWAIT is 0 SHALL stall the strobe counter and extend STROBE by one cycle.
REQ-033 With HOST_MASTER_WAIT_EN defined, if the stall count reaches TIMEOUT_CYC the FSM SHALL go to HOLD, set rsp_err to 1 with rsp_valid and force rsp_rdata to 0; the stall count SHALL reset on each accepted request.
REQ-034 Without HOST_MASTER_WAIT_EN, HOST_nWAIT SHALL be ignored, rsp_err SHALL be constant 0, and no stall counter SHALL be synthesized.

Verification
REQ-035 Write 0x00006/0xBEEF with default parameters -> HOST_nCS low 5 cycles, HOST_nWE low cycles 2-4, HOST_DO=0xBEEF throughout, rsp_valid in cycle 6 after acceptance.
REQ-036 Read 0x00002 with HOST_DI=0x1234 during STROBE -> HOST_nOE low 3 cycles, rsp_rdata=0x1234, rsp_err=0.
REQ-037 req_valid held high for two requests -> second accepted on the IDLE cycle after RESP, HOST_nCS high 2 cycles between transactions, req_ready low while busy.
REQ-038 nRESET pulsed low during write STROBE -> all strobes 1 asynchronously, no rsp_valid, req_ready=1 after release.
REQ-039 With the macro, HOST_nWAIT low 10 STROBE cycles -> nOE low 13 cycles, rsp_err=0; HOST_nWAIT held low >255 cycles -> rsp_err=1, rsp_rdata=0.
REQ-040 Without the macro, HOST_nWAIT held low -> timing identical to REQ-036.
